// File: rtl/data_c_pipe_sched.sv
// Round-robin scheduler feeding a shared fixed-latency valid/ready pipe.
// Define DATA_C_PIPE_SCHED_CHECK_EN to enable the sticky tag/valid checker.
module data_c_pipe_sched #(
  parameter int NUM   = 4,
  parameter int DSIZE = 8,
  parameter int LAT   = 4
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic [NUM-1:0]           s_valid,
  input  logic [NUM*DSIZE-1:0]     s_data,
  output logic [NUM-1:0]           s_ready,
  output logic                     p_valid,
  output logic [DSIZE-1:0]         p_data,
  input  logic                     p_ready,
  input  logic                     r_valid,
  input  logic [DSIZE-1:0]         r_data,
  output logic                     r_ready,
  output logic [NUM-1:0]           m_valid,
  output logic [DSIZE-1:0]         m_data,
  input  logic [NUM-1:0]           m_ready,
  output logic [$clog2(LAT+1)-1:0] inflight,
  output logic                     err
);

  localparam int TW = $clog2(NUM);
  localparam int IW = $clog2(LAT+1);

  logic [TW-1:0]  r_ptr;
  logic [LAT-1:0] r_tag_vld;
  logic [TW-1:0]  r_tag [LAT];
  logic [IW-1:0]  r_inflight;

  logic [TW-1:0]  w_gnt;
  logic [TW-1:0]  w_ptr_nxt;
  logic [IW-1:0]  w_inf_nxt;

  always_comb begin : arb
    logic [TW:0] sum;
    logic        found;
    sum   = '0;
    found = 1'b0;
    w_gnt = '0;
    for (int k = 0; k < NUM; k++) begin
      sum = {1'b0, r_ptr} + (TW+1)'(k);
      if (sum >= (TW+1)'(NUM))
        sum = sum - (TW+1)'(NUM);
      if (!found && s_valid[sum[TW-1:0]]) begin
        w_gnt = sum[TW-1:0];
        found = 1'b1;
      end
    end
  end

  assign p_valid = |s_valid;
  assign p_data  = s_data[w_gnt*DSIZE +: DSIZE];

  always_comb begin
    s_ready = '0;
    for (int i = 0; i < NUM; i++)
      s_ready[i] = (w_gnt == TW'(i)) & s_valid[i] & p_ready;
  end

  assign w_ptr_nxt = (w_gnt == TW'(NUM-1)) ? '0 : w_gnt + 1'b1;

  // Count follows the shift: one tag enters, the tail tag leaves.
  assign w_inf_nxt = r_inflight + IW'(p_valid)
                   - IW'(r_tag_vld[LAT-1]);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_tag_vld  <= '0;
      r_inflight <= '0;
      for (int k = 0; k < LAT; k++)
        r_tag[k] <= '0;
    end else begin
      if (p_valid && p_ready)
        r_ptr <= w_ptr_nxt;
      if (p_ready) begin
        r_tag_vld[0] <= p_valid;
        r_tag[0]     <= w_gnt;
        for (int k = 1; k < LAT; k++) begin
          r_tag_vld[k] <= r_tag_vld[k-1];
          r_tag[k]     <= r_tag[k-1];
        end
        r_inflight <= w_inf_nxt;
      end
    end
  end

  always_comb begin
    m_valid = '0;
    for (int i = 0; i < NUM; i++)
      m_valid[i] = r_valid & r_tag_vld[LAT-1]
                 & (r_tag[LAT-1] == TW'(i));
  end

  assign m_data   = r_data;
  assign r_ready  = ~r_tag_vld[LAT-1] | m_ready[r_tag[LAT-1]];
  assign inflight = r_inflight;

`ifdef DATA_C_PIPE_SCHED_CHECK_EN
  logic r_err;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)
      r_err <= 1'b0;
    else if (r_valid != r_tag_vld[LAT-1])
      r_err <= 1'b1;
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_data_c_pipe_sched.sv
// Directed bench for data_c_pipe_sched with an external LAT-stage pipe
// model and a grant-order scoreboard checked by an independent monitor.
module tb_data_c_pipe_sched;
  localparam int NUM   = 4;
  localparam int DSIZE = 8;
  localparam int LAT   = 4;

`ifdef DATA_C_PIPE_SCHED_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  logic [NUM-1:0]       s_valid;
  logic [NUM*DSIZE-1:0] s_data;
  logic [NUM-1:0]       s_ready;
  logic                 p_valid;
  logic [DSIZE-1:0]     p_data;
  logic                 p_ready;
  logic                 r_valid;
  logic [DSIZE-1:0]     r_data;
  logic                 r_ready;
  logic [NUM-1:0]       m_valid;
  logic [DSIZE-1:0]     m_data;
  logic [NUM-1:0]       m_ready;
  logic [2:0]           inflight;
  logic                 err;
  logic                 force_rv;

  data_c_pipe_sched #(.NUM(NUM), .DSIZE(DSIZE), .LAT(LAT)) dut (
    .clock    (clock),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .p_valid  (p_valid),
    .p_data   (p_data),
    .p_ready  (p_ready),
    .r_valid  (r_valid),
    .r_data   (r_data),
    .r_ready  (r_ready),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_ready  (m_ready),
    .inflight (inflight),
    .err      (err)
  );

  // Shared pipe: advances on the same condition as the result side.
  logic [LAT-1:0]   pv;
  logic [DSIZE-1:0] pd [LAT];

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
      for (int k = 0; k < LAT; k++) pd[k] <= '0;
    end else if (p_ready) begin
      pv    <= {pv[LAT-2:0], p_valid};
      pd[0] <= p_data;
      for (int k = 1; k < LAT; k++) pd[k] <= pd[k-1];
    end
  end

  assign r_valid = pv[LAT-1] | force_rv;
  assign r_data  = pd[LAT-1];
  assign p_ready = r_ready;

  typedef struct packed {
    logic [1:0]       id;
    logic [DSIZE-1:0] d;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   stp     = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle; exp_rdy is the hand-computed grant for it.
  task automatic step(logic [3:0] sv, logic [3:0] mr,
                      logic [3:0] exp_rdy);
    @(posedge clock);
    #1;
    stp++;
    s_valid = sv;
    m_ready = mr;
    for (int i = 0; i < NUM; i++)
      s_data[i*DSIZE +: DSIZE] = {stp[3:0], 4'(i)};
    @(negedge clock);
    chk("s_ready", 32'(s_ready), 32'(exp_rdy));
    for (int i = 0; i < NUM; i++)
      if (exp_rdy[i])
        sb.push_back('{id: 2'(i), d: {stp[3:0], 4'(i)}});
  endtask

  task automatic idle(int n);
    for (int j = 0; j < n; j++) step(4'h0, 4'hF, 4'h0);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (rst_n && (m_valid & m_ready) != '0) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'(m_valid), 32'h0);
      end else begin
        e = sb.pop_front();
        chk("result_id", 32'(m_valid), 32'(4'b0001 << e.id));
        chk("result_data", 32'(m_data), 32'(e.d));
      end
    end
  end

  initial begin
    s_valid  = '0;
    s_data   = '0;
    m_ready  = '1;
    force_rv = 1'b0;

    repeat (2) @(negedge clock);
    chk("rst_inflight", 32'(inflight), 32'h0);
    chk("rst_m_valid", 32'(m_valid), 32'h0);
    chk("rst_r_ready", 32'(r_ready), 32'h1);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_p_valid", 32'(p_valid), 32'h0);
    #2 rst_n = 1'b1;

    // All request: rotating grants, first result after LAT cycles.
    for (int k = 0; k < 8; k++) begin
      step(4'hF, 4'hF, 4'b0001 << (k % 4));
      if (k == 3) begin
        chk("a_m_valid_k3", 32'(m_valid), 32'h0);
        chk("a_inflight_k3", 32'(inflight), 32'h3);
      end
      if (k == 4) begin
        chk("a_m_valid_k4", 32'(m_valid), 32'h1);
        chk("a_inflight_k4", 32'(inflight), 32'h4);
      end
    end
    idle(5);
    chk("a_drained", 32'(inflight), 32'h0);

    // Single requester granted every cycle.
    for (int k = 0; k < 5; k++) begin
      step(4'b0100, 4'hF, 4'b0100);
      if (k == 3) chk("b_m_valid_k3", 32'(m_valid), 32'h0);
      if (k == 4) chk("b_m_valid_k4", 32'(m_valid), 32'h4);
    end
    idle(5);
    chk("b_drained", 32'(inflight), 32'h0);

    // Backpressure on requester 1 freezes the pipe.
    step(4'b0010, 4'hF, 4'b0010);
    idle(3);
    for (int k = 0; k < 3; k++) begin
      step(4'hF, 4'b1101, 4'h0);
      chk("c_m_valid_stall", 32'(m_valid), 32'h2);
      chk("c_r_ready_stall", 32'(r_ready), 32'h0);
      chk("c_inflight_stall", 32'(inflight), 32'h1);
    end
    step(4'h0, 4'hF, 4'h0);
    chk("c_r_ready_release", 32'(r_ready), 32'h1);
    step(4'hF, 4'hF, 4'b0100);
    idle(5);
    chk("c_drained", 32'(inflight), 32'h0);

    // Alternating requester 0 leaves a bubble between results.
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) step(4'h1, 4'hF, 4'h1);
      else            step(4'h0, 4'hF, 4'h0);
      if (k >= 4) begin
        chk("d_m_valid", 32'(m_valid), (k % 2 == 0) ? 32'h1 : 32'h0);
        chk("d_inflight", 32'(inflight), 32'h2);
      end
    end
    idle(5);

    // Reset with three tags in flight.
    step(4'hF, 4'hF, 4'b0010);
    step(4'hF, 4'hF, 4'b0100);
    step(4'hF, 4'hF, 4'b1000);
    @(posedge clock);
    #1;
    s_valid = '0;
    chk("e_inflight_pre", 32'(inflight), 32'h3);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("e_rst_inflight", 32'(inflight), 32'h0);
    chk("e_rst_m_valid", 32'(m_valid), 32'h0);
    chk("e_rst_r_ready", 32'(r_ready), 32'h1);
    @(negedge clock);
    #2 rst_n = 1'b1;
    step(4'hF, 4'hF, 4'b0001);
    idle(5);

    // Spurious r_valid with an empty tail tag.
    @(posedge clock);
    #1 force_rv = 1'b1;
    @(posedge clock);
    #1 force_rv = 1'b0;
    @(negedge clock);
    chk("f_err_set", 32'(err), 32'(EXP_ERR));
    @(negedge clock);
    chk("f_err_sticky", 32'(err), 32'(EXP_ERR));

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
